// File: rtl/y86_regfile_pkg.sv
// Shared register-file definitions: ID width, the "no register" ID and architectural register names.
package y86_regfile_pkg;

   localparam int ID_W = 4;
   localparam logic [ID_W-1:0] RNONE = 4'hF;

   typedef enum logic [ID_W-1:0] {
      REG_EAX  = 4'd0,
      REG_ECX  = 4'd1,
      REG_EDX  = 4'd2,
      REG_EBX  = 4'd3,
      REG_ESP  = 4'd4,
      REG_EBP  = 4'd5,
      REG_ESI  = 4'd6,
      REG_EDI  = 4'd7,
      REG_NONE = 4'hF
   } reg_id_e;

   function automatic logic id_in_range(input logic [ID_W-1:0] id, input int nreg);
      return int'(id) < nreg;
   endfunction

endpackage

// File: rtl/y86_reg_read_mux.sv
// One combinational read port: range-checked register select with optional same-cycle write bypass.
module y86_reg_read_mux #(
   parameter int DATA_W = 32,
   parameter int NREG   = 8,
   parameter int ID_W   = 4,
   parameter bit BYPASS = 1'b0
) (
   input  logic [ID_W-1:0]             src,
   input  logic [NREG-1:0][DATA_W-1:0] regs_i,
   input  logic                        wr_e,
   input  logic [ID_W-1:0]             dst_e,
   input  logic [DATA_W-1:0]           val_e,
   input  logic                        wr_m,
   input  logic [ID_W-1:0]             dst_m,
   input  logic [DATA_W-1:0]           val_m,
   output logic [DATA_W-1:0]           val
);
   import y86_regfile_pkg::*;

   logic [DATA_W-1:0] stored;

   always_comb begin
      stored = '0;
      for (int i = 0; i < NREG; i++) begin
         if (src == ID_W'(i)) stored = regs_i[i];
      end
      val = id_in_range(src, NREG) ? stored : '0;
      // wr_e/wr_m already imply an in-range ID, so a hit is always a legal register
      if (BYPASS && wr_e && (dst_e == src)) val = val_e;
      if (BYPASS && wr_m && (dst_m == src)) val = val_m;
   end

endmodule

// File: rtl/y86_regfile_mp.sv
// Y86 register file: two write ports (E, M), two read ports (A, B), conflict/bad-ID flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module y86_regfile_mp #(
   parameter int              DATA_W = 32,
   parameter int              NREG   = 8,
   parameter int              ID_W   = y86_regfile_pkg::ID_W,
   parameter logic [ID_W-1:0] RNONE  = y86_regfile_pkg::RNONE
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   stall,
   input  logic [ID_W-1:0]        dstE,
   input  logic [DATA_W-1:0]      valE,
   input  logic [ID_W-1:0]        dstM,
   input  logic [DATA_W-1:0]      valM,
   input  logic [ID_W-1:0]        srcA,
   input  logic [ID_W-1:0]        srcB,
   output logic [DATA_W-1:0]      valA,
   output logic [DATA_W-1:0]      valB,
   output logic [NREG*DATA_W-1:0] regs,
   output logic                   conflict,
   output logic                   bad_id
);
   import y86_regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [NREG-1:0][DATA_W-1:0] reg_q, reg_d;
   logic conflict_q, conflict_d;
   logic bad_id_q, bad_id_d;
   logic wr_e, wr_m, bad_e, bad_m;

   always_comb begin
      wr_e  = !stall && id_in_range(dstE, NREG);
      wr_m  = !stall && id_in_range(dstM, NREG);
      bad_e = (dstE != RNONE) && !id_in_range(dstE, NREG);
      bad_m = (dstM != RNONE) && !id_in_range(dstM, NREG);

      reg_d = reg_q;
      for (int i = 0; i < NREG; i++) begin
         if (wr_e && (dstE == ID_W'(i))) reg_d[i] = valE;
      end
      // M applied after E so it wins on a same-ID dual write
      for (int i = 0; i < NREG; i++) begin
         if (wr_m && (dstM == ID_W'(i))) reg_d[i] = valM;
      end

      conflict_d = wr_e && wr_m && (dstE == dstM);
      bad_id_d   = bad_id_q || (!stall && (bad_e || bad_m));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         reg_q      <= '0;
         conflict_q <= 1'b0;
         bad_id_q   <= 1'b0;
      end else begin
         reg_q      <= reg_d;
         conflict_q <= conflict_d;
         bad_id_q   <= bad_id_d;
      end
   end

   y86_reg_read_mux #(.DATA_W(DATA_W), .NREG(NREG), .ID_W(ID_W), .BYPASS(BYPASS_EN)) u_read_a (
      .src(srcA), .regs_i(reg_q),
      .wr_e(wr_e), .dst_e(dstE), .val_e(valE),
      .wr_m(wr_m), .dst_m(dstM), .val_m(valM),
      .val(valA)
   );

   y86_reg_read_mux #(.DATA_W(DATA_W), .NREG(NREG), .ID_W(ID_W), .BYPASS(BYPASS_EN)) u_read_b (
      .src(srcB), .regs_i(reg_q),
      .wr_e(wr_e), .dst_e(dstE), .val_e(valE),
      .wr_m(wr_m), .dst_m(dstM), .val_m(valM),
      .val(valB)
   );

   assign regs     = reg_q;
   assign conflict = conflict_q;
   assign bad_id   = bad_id_q;

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Self-checking bench for y86_regfile_mp: vector table, corner sequences, random run against a model.
module tb_y86_regfile_mp;

   logic         clock = 1'b0;
   logic         reset, stall;
   logic [3:0]   dstE, dstM, srcA, srcB;
   logic [31:0]  valE, valM, valA, valB;
   logic [255:0] regs;
   logic         conflict, bad_id;

   int n_run  = 0;
   int n_fail = 0;

   logic [31:0] m_reg [8];
   logic        m_conf, m_bad;

   y86_regfile_mp dut (
      .clock(clock), .reset(reset), .stall(stall),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
      .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .regs(regs), .conflict(conflict), .bad_id(bad_id)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        st;
      logic [3:0]  dE;
      logic [31:0] vE;
      logic [3:0]  dM;
      logic [31:0] vM;
      logic [3:0]  sA;
      logic [3:0]  sB;
      logic [31:0] eA;
      logic [31:0] eB;
      logic        eConf;
      logic        eBad;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic st, input logic [3:0] dE, input logic [31:0] vE,
                         input logic [3:0] dM, input logic [31:0] vM,
                         input logic [3:0] sA, input logic [3:0] sB);
      stall = st; dstE = dE; valE = vE; dstM = dM; valM = vM; srcA = sA; srcB = sB;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] s);
      logic [31:0] r;
      r = (s < 4'd8) ? m_reg[s[2:0]] : 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (!stall && dstE < 4'd8 && dstE == s) r = valE;
      if (!stall && dstM < 4'd8 && dstM == s) r = valM;
`endif
      return r;
   endfunction

   // Reference behaviour for one rising edge, from the current inputs.
   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
         m_conf = 1'b0;
         m_bad  = 1'b0;
      end else if (stall) begin
         m_conf = 1'b0;
      end else begin
         m_conf = (dstE == dstM) && (dstE < 4'd8);
         if (dstE < 4'd8) m_reg[dstE[2:0]] = valE;
         if (dstM < 4'd8) m_reg[dstM[2:0]] = valM;
         if ((dstE >= 4'd8 && dstE != 4'hF) || (dstM >= 4'd8 && dstM != 4'hF)) m_bad = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), regs[i*32 +: 32], m_reg[i]);
      chk("conflict", {31'b0, conflict}, {31'b0, m_conf});
      chk("bad_id", {31'b0, bad_id}, {31'b0, m_bad});
   endtask

   task automatic chk_reads(input string tag);
      #1;
      chk({tag, "_valA"}, valA, m_read(srcA));
      chk({tag, "_valB"}, valB, m_read(srcB));
   endtask

   initial begin
      tbl[0] = '{1'b0, 4'd2, 32'h1111, 4'd5, 32'h2222, 4'd2, 4'd5, 32'h1111, 32'h2222, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 4'd3, 32'hAAAA, 4'd3, 32'hBBBB, 4'd3, 4'd2, 32'hBBBB, 32'h1111, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 4'hF, 32'h1,    4'hF, 32'h2,    4'd3, 4'd5, 32'hBBBB, 32'h2222, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 4'd1, 32'h5,    4'hF, 32'h0,    4'd1, 4'hF, 32'h0,    32'h0,    1'b0, 1'b0};
      tbl[4] = '{1'b0, 4'd1, 32'h5,    4'hF, 32'h0,    4'd1, 4'hF, 32'h5,    32'h0,    1'b0, 1'b0};
      tbl[5] = '{1'b0, 4'd9, 32'hDEAD, 4'hF, 32'h0,    4'd9, 4'd1, 32'h0,    32'h5,    1'b0, 1'b1};
      tbl[6] = '{1'b0, 4'd0, 32'h77,   4'hF, 32'h0,    4'd0, 4'd3, 32'h77,   32'hBBBB, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 4'd4, 32'h4,    4'd4, 32'h4,    4'd4, 4'd0, 32'h0,    32'h77,   1'b0, 1'b1};
      tbl[8] = '{1'b0, 4'hF, 32'h0,    4'd12, 32'h1234, 4'd7, 4'd6, 32'h0,   32'h0,    1'b0, 1'b1};

      for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
      m_conf = 1'b0;
      m_bad  = 1'b0;
      reset  = 1'b1;
      set_in(1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 4'hF, 4'hF);
      step();
      step();
      reset = 1'b0;

      // Random writes, then a single reset edge that also carries a write.
      for (int i = 0; i < 5; i++) begin
         set_in(1'b0, 4'($urandom_range(0, 9)), $urandom, 4'($urandom_range(0, 9)), $urandom, 4'hF, 4'hF);
         step();
      end
      reset = 1'b1;
      set_in(1'b0, 4'd1, 32'h5, 4'd2, 32'h6, 4'hF, 4'hF);
      step();
      reset = 1'b0;
      set_in(1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 4'd1, 4'd2);
      chk_reads("after_reset");
      chk("rst_r1", regs[63:32], 32'h0);

      // Vector table: one write edge, then read back with writes idle.
      for (int v = 0; v < 9; v++) begin
         set_in(tbl[v].st, tbl[v].dE, tbl[v].vE, tbl[v].dM, tbl[v].vM, 4'hF, 4'hF);
         step();
         set_in(1'b0, 4'hF, 32'h0, 4'hF, 32'h0, tbl[v].sA, tbl[v].sB);
         #1;
         chk($sformatf("tbl%0d_valA", v), valA, tbl[v].eA);
         chk($sformatf("tbl%0d_valB", v), valB, tbl[v].eB);
         chk($sformatf("tbl%0d_conflict", v), {31'b0, conflict}, {31'b0, tbl[v].eConf});
         chk($sformatf("tbl%0d_bad_id", v), {31'b0, bad_id}, {31'b0, tbl[v].eBad});
      end

      // Back-to-back conflicts, then a stalled conflicting write clears the pulse.
      reset = 1'b1;
      set_in(1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 4'hF, 4'hF);
      step();
      reset = 1'b0;
      set_in(1'b0, 4'd5, 32'h10, 4'd5, 32'h20, 4'hF, 4'hF);
      step();
      set_in(1'b0, 4'd5, 32'h30, 4'd5, 32'h40, 4'hF, 4'hF);
      step();
      chk("conf_repeat", {31'b0, conflict}, 32'h1);
      set_in(1'b1, 4'd5, 32'h50, 4'd5, 32'h60, 4'hF, 4'hF);
      step();
      chk("conf_stall", {31'b0, conflict}, 32'h0);
      chk("r5_stall", regs[191:160], 32'h40);
      set_in(1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 4'hF, 4'hF);
      for (int i = 0; i < 3; i++) step();

      // Same-cycle read of a register being written.
      set_in(1'b0, 4'hF, 32'h0, 4'd6, 32'hCAFE, 4'd6, 4'hF);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("same_cycle_valA", valA, 32'hCAFE);
`else
      chk("same_cycle_valA", valA, 32'h0);
`endif
      step();
      set_in(1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 4'd6, 4'hF);
      #1;
      chk("next_cycle_valA", valA, 32'hCAFE);

      // Randomized run against the model.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 24) == 0);
         set_in(($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         chk_reads("rand");
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
